fb_write_ctrl: RTL and testbench



---
 rtl/fb_write_ctrl.sv | 124 ++++++++++++
 tb/tb_fb_write_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_ctrl.sv
// fb_write_ctrl
// Owns the framebuffer write port and shares it between two sources:
// - the draw requester (pen/paint path)
// - an internal clear engine that sweeps addresses 0..NUM_PIXELS-1 to CLEAR_VALUE
// It issues at most one pixel write per clock. The framebuffer read port is
// not touched here.
//
// Ports
//   Clk          clock; also the framebuffer wrclock
//   Reset_n      asynchronous active-low reset
//   clear_start  single-cycle clear request (ignored while a clear is running)
//   clear_busy   high while clear writes are on the write port
//   clear_done   one-cycle pulse alongside the last clear write
//   draw_req     draw request, held by the requester until draw_ack
//   draw_addr    draw pixel address, valid with draw_req
//   draw_data    draw pixel value, valid with draw_req
//   draw_ack     combinational accept of the draw request
//   draw_drop    one-cycle pulse: an accepted draw was out of range and not written
//   fb_wraddress framebuffer write address
//   fb_data      framebuffer write data
//   fb_wren      framebuffer write enable
//
// State  | meaning
// IDLE   | accept draw requests; a clear_start moves to CLEAR
// CLEAR  | write CLEAR_VALUE to one address per cycle, draws stalled

module fb_write_ctrl #(
    parameter int                ADDR_W      = 17,
    parameter int                DATA_W      = 8,
    parameter int                NUM_PIXELS  = 76800,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    input  logic              draw_req,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic [DATA_W-1:0] draw_data,
    output logic              draw_ack,
    output logic              draw_drop,
    output logic [ADDR_W-1:0] fb_wraddress,
    output logic [DATA_W-1:0] fb_data,
    output logic              fb_wren
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    // One extra bit so NUM_PIXELS == 2**ADDR_W is representable and every
    // address compares as in range.
    localparam logic [ADDR_W:0]   NUM_P     = NUM_PIXELS[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_next;
    logic              in_range;

    assign cnt_next = cnt + ONE;
    assign in_range = ({1'b0, draw_addr} < NUM_P);

    // clear_start outranks a simultaneous draw; reset forces the ack low so a
    // requester cannot advance on a request that will never be written.
    assign draw_ack = Reset_n && (state == IDLE) && !clear_start && draw_req;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            fb_wren      <= 1'b0;
            fb_wraddress <= '0;
            fb_data      <= '0;
            clear_busy   <= 1'b0;
            clear_done   <= 1'b0;
            draw_drop    <= 1'b0;
        end else begin
            draw_drop  <= 1'b0;
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state        <= CLEAR;
                        cnt          <= '0;
                        fb_wren      <= 1'b1;
                        fb_wraddress <= '0;
                        fb_data      <= CLEAR_VALUE;
                        clear_busy   <= 1'b1;
                    end else if (draw_ack) begin
                        if (in_range) begin
                            fb_wren      <= 1'b1;
                            fb_wraddress <= draw_addr;
                            fb_data      <= draw_data;
                        end else begin
                            // address/data keep their last values on a drop
                            fb_wren   <= 1'b0;
                            draw_drop <= 1'b1;
                        end
                    end else begin
                        fb_wren <= 1'b0;
                    end
                end
                CLEAR: begin
                    // cnt mirrors the address currently on the write port
                    if (cnt == LAST_ADDR) begin
                        state      <= IDLE;
                        fb_wren    <= 1'b0;
                        clear_busy <= 1'b0;
                    end else begin
                        cnt          <= cnt_next;
                        fb_wraddress <= cnt_next;
                        clear_done   <= (cnt_next == LAST_ADDR);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_write_ctrl.sv
module tb_fb_write_ctrl;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 8;
    localparam int NPIX   = 16;

    logic              clk_sys;
    logic              rst_n;
    logic              clear_start;
    logic              clear_busy;
    logic              clear_done;
    logic              draw_req;
    logic [ADDR_W-1:0] draw_addr;
    logic [DATA_W-1:0] draw_data;
    logic              draw_ack;
    logic              draw_drop;
    logic [ADDR_W-1:0] fb_wraddress;
    logic [DATA_W-1:0] fb_data;
    logic              fb_wren;

    fb_write_ctrl #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .NUM_PIXELS  (NPIX),
        .CLEAR_VALUE (8'h00)
    ) dut (
        .Clk          (clk_sys),
        .Reset_n      (rst_n),
        .clear_start  (clear_start),
        .clear_busy   (clear_busy),
        .clear_done   (clear_done),
        .draw_req     (draw_req),
        .draw_addr    (draw_addr),
        .draw_data    (draw_data),
        .draw_ack     (draw_ack),
        .draw_drop    (draw_drop),
        .fb_wraddress (fb_wraddress),
        .fb_data      (fb_data),
        .fb_wren      (fb_wren)
    );

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              done;
        logic              clr;
    } wr_t;

    wr_t wq[$];
    int  dq[$];
    wr_t e_mon;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h (t=%0t cyc=%0d)", tag, got, exp, $time, cyc);
    endtask

    // Expected writes for cycles c+1..c+NPIX after clear_start is sampled in cycle c.
    task automatic push_clear(input int c);
        wr_t w;
        for (int i = 0; i < NPIX; i++) begin
            w.cyc  = c + 1 + i;
            w.addr = ADDR_W'(i);
            w.data = 8'h00;
            w.done = (i == NPIX - 1);
            w.clr  = 1'b1;
            wq.push_back(w);
        end
    endtask

    // Presents a draw request and holds it until acked (bounded wait).
    task automatic draw(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        output int ack_cyc, output int waits);
        wr_t w;
        bit  got;
        draw_req  = 1'b1;
        draw_addr = a;
        draw_data = d;
        waits     = 0;
        ack_cyc   = -1;
        got       = 1'b0;
        while (waits <= 40) begin
            @(negedge clk_sys);
            if (draw_ack) begin
                got = 1'b1;
                break;
            end
            waits++;
            @(posedge clk_sys);
            #1;
        end
        if (!got) begin
            chk("ack_timeout", 32'd0, 32'd1);
        end else begin
            ack_cyc = cyc;
            if (a < ADDR_W'(NPIX)) begin
                w.cyc  = cyc + 1;
                w.addr = a;
                w.data = d;
                w.done = 1'b0;
                w.clr  = 1'b0;
                wq.push_back(w);
            end else begin
                dq.push_back(cyc + 1);
            end
        end
        @(posedge clk_sys);
        #1;
        draw_req = 1'b0;
    endtask

    always @(negedge clk_sys) begin
        if (rst_n) begin
            if (fb_wren) begin
                if (wq.size() == 0) begin
                    chk("unexp_wr", {15'd0, fb_wraddress}, 32'hFFFF_FFFF);
                end else begin
                    e_mon = wq.pop_front();
                    chk("wr_cyc",  cyc,          e_mon.cyc);
                    chk("wr_addr", fb_wraddress, e_mon.addr);
                    chk("wr_data", fb_data,      e_mon.data);
                    chk("wr_done", clear_done,   e_mon.done);
                    chk("wr_busy", clear_busy,   e_mon.clr);
                end
            end else begin
                chk("idle_done", clear_done, 1'b0);
                chk("idle_busy", clear_busy, 1'b0);
            end
            if (draw_drop) begin
                if (dq.size() == 0) chk("unexp_drop", 32'd1, 32'd0);
                else                chk("drop_cyc", cyc, dq.pop_front());
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int ac;
        int wt;

        rst_n       = 1'b0;
        clear_start = 1'b0;
        draw_req    = 1'b0;
        draw_addr   = '0;
        draw_data   = '0;
        #1;
        chk("rst_wren", fb_wren,      1'b0);
        chk("rst_addr", fb_wraddress, '0);
        chk("rst_data", fb_data,      '0);
        chk("rst_busy", clear_busy,   1'b0);
        chk("rst_done", clear_done,   1'b0);
        chk("rst_drop", draw_drop,    1'b0);
        draw_req = 1'b1;
        #1;
        chk("rst_ack_forced", draw_ack, 1'b0);
        draw_req = 1'b0;
        repeat (2) @(posedge clk_sys);
        #2 rst_n = 1'b1;
        @(negedge clk_sys);
        chk("idle_ack", draw_ack, 1'b0);
        chk("idle_wren", fb_wren, 1'b0);

        // full clear
        @(posedge clk_sys); #1;
        clear_start = 1'b1;
        c = cyc;
        push_clear(c);
        @(posedge clk_sys); #1;
        clear_start = 1'b0;
        repeat (20) @(posedge clk_sys);
        #1;

        // back-to-back draw burst
        draw(17'd5, 8'hFF, ac, wt); chk("burst0_wait", wt, 0);
        c = ac;
        draw(17'd6, 8'h80, ac, wt); chk("burst1_wait", wt, 0); chk("burst1_cyc", ac, c + 1);
        draw(17'd7, 8'h01, ac, wt); chk("burst2_wait", wt, 0); chk("burst2_cyc", ac, c + 2);
        repeat (2) @(posedge clk_sys);
        #1;

        // range boundary
        draw(17'd16,    8'hAA, ac, wt); chk("oor16_wait", wt, 0);
        draw(17'd15,    8'h3C, ac, wt); chk("last_wait",  wt, 0);
        draw(17'h1FFFF, 8'h55, ac, wt); chk("oormax_wait", wt, 0);
        repeat (2) @(posedge clk_sys);
        #1;
        chk("drop_hold_addr", fb_wraddress, 17'd15);
        chk("drop_hold_data", fb_data,      8'h3C);

        // clear_start and draw in the same cycle: clear wins, draw waits
        clear_start = 1'b1;
        draw_req    = 1'b1;
        draw_addr   = 17'd3;
        draw_data   = 8'h5A;
        c = cyc;
        @(negedge clk_sys);
        chk("conf_ack0", draw_ack, 1'b0);
        push_clear(c);
        @(posedge clk_sys); #1;
        clear_start = 1'b0;
        draw(17'd3, 8'h5A, ac, wt);
        chk("conf_ack_cyc", ac, c + 17);
        repeat (3) @(posedge clk_sys);
        #1;

        // restart attempt mid-clear is ignored
        clear_start = 1'b1;
        c = cyc;
        push_clear(c);
        @(posedge clk_sys); #1;
        clear_start = 1'b0;
        repeat (4) @(posedge clk_sys);
        #1;
        clear_start = 1'b1;
        @(posedge clk_sys); #1;
        clear_start = 1'b0;
        repeat (20) @(posedge clk_sys);
        #1;

        // reset in the middle of a clear
        clear_start = 1'b1;
        c = cyc;
        push_clear(c);
        @(posedge clk_sys); #1;
        clear_start = 1'b0;
        repeat (7) @(posedge clk_sys);
        #1;
        chk("pre_rst_addr", fb_wraddress, 17'd7);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_wren", fb_wren,    1'b0);
        chk("midrst_addr", fb_wraddress, '0);
        chk("midrst_busy", clear_busy, 1'b0);
        wq.delete();
        draw_req  = 1'b1;
        draw_addr = 17'd9;
        draw_data = 8'h33;
        #1;
        chk("midrst_ack", draw_ack, 1'b0);
        @(posedge clk_sys);
        #2 rst_n = 1'b1;
        draw(17'd9, 8'h33, ac, wt);
        chk("post_rst_wait", wt, 0);
        repeat (20) @(posedge clk_sys);
        #1;

        chk("wq_empty", wq.size(), 0);
        chk("dq_empty", dq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
